int_ctrl: RTL and testbench

Memory-mapped interrupt controller on the CPU data bus, feeding the CPU's `int` input. It synchronizes external interrupt sources and latches them per source as edge or level. It then selects the highest-priority enabled pending source and holds a one-hot request on `int_o` until software claims it. It answers reads and writes on the shared data-bus signals (`mem_addr`, `mem_wd`, `mem_rd`, `mem_ctrl`) and acts only in its own address window.

---
 rtl/int_ctrl.sv | 158 +++++++++++++++
 tb/tb_int_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// Memory-mapped interrupt controller: per-source sync + edge/level pending,
// fixed lowest-index priority, assert/claim/complete handshake to the CPU.

module int_ctrl_src (
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic edge_mode,
  input  logic clr,
  output logic pend
);
  logic sync1, sync2, prev, pend_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      prev   <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      sync1 <= src;
      sync2 <= sync1;
      prev  <= sync2;
      // A fresh edge beats a same-cycle clear so no event is lost.
      if (!edge_mode)          pend_q <= 1'b0;
      else if (sync2 && !prev) pend_q <= 1'b1;
      else if (clr)            pend_q <= 1'b0;
    end
  end

  assign pend = edge_mode ? pend_q : sync2;
endmodule

module int_ctrl #(
  parameter int              DW   = 16,
  parameter int              AW   = 16,
  parameter int              NSRC = 8,
  parameter logic [AW-1:0]   BASE = 16'hFF00
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src_i,
  input  logic [AW-1:0]   mem_addr,
  input  logic [DW-1:0]   mem_wd,
  input  logic            mem_ctrl,
  output logic [DW-1:0]   mem_rd,
  output logic            sel,
  output logic [NSRC-1:0] int_o
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ASSERT = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;

  logic [1:0]      state;
  logic [3:0]      cur_id;
  logic [NSRC-1:0] enable, edge_mode, pend, act, clr, cand_oh;
  logic [3:0]      cand_id;
  logic            cur_act;
  logic [2:0]      off;
  logic            wr, wr_pend, claim_wr, cmpl_ok;
  logic [DW-1:0]   rd;

  assign off      = mem_addr[2:0];
  assign sel      = (mem_addr[AW-1:3] == BASE[AW-1:3]);
  assign wr       = sel && mem_ctrl;
  assign wr_pend  = wr && (off == 3'd0);
  assign claim_wr = wr && (off == 3'd2) && (state == S_ASSERT);
  assign cmpl_ok  = wr && (off == 3'd3) && (state == S_WAIT) && (mem_wd == DW'(cur_id));
  assign act      = pend & enable;

  genvar g;
  generate
    for (g = 0; g < NSRC; g++) begin : g_src
      assign clr[g] = (wr_pend && mem_wd[g]) || (cmpl_ok && (cur_id == 4'(g + 1)));
      int_ctrl_src u_src (
        .clk       (clk),
        .rst       (rst),
        .src       (src_i[g]),
        .edge_mode (edge_mode[g]),
        .clr       (clr[g]),
        .pend      (pend[g])
      );
    end
  endgenerate

  // Lowest active index wins; ID is index+1 so 0 can mean "none".
  always_comb begin
    cand_id = 4'd0;
    cand_oh = '0;
    cur_act = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--)
      if (act[i]) cand_id = 4'(i + 1);
    for (int i = 0; i < NSRC; i++) begin
      cand_oh[i] = (cand_id == 4'(i + 1));
      if (cur_id == 4'(i + 1)) cur_act = act[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable    <= '0;
      edge_mode <= '0;
    end else if (wr) begin
      if (off == 3'd1) enable    <= mem_wd[NSRC-1:0];
      if (off == 3'd4) edge_mode <= mem_wd[NSRC-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cur_id <= 4'd0;
      int_o  <= '0;
    end else begin
      case (state)
        S_IDLE:
          if (cand_id != 4'd0) begin
            state  <= S_ASSERT;
            cur_id <= cand_id;
            int_o  <= cand_oh;
          end
        S_ASSERT:
          if (claim_wr) begin
            state <= S_WAIT;
            int_o <= '0;
          end else if (!cur_act) begin
            state  <= S_IDLE;
            cur_id <= 4'd0;
            int_o  <= '0;
          end
        S_WAIT:
          if (cmpl_ok) begin
            state  <= S_IDLE;
            cur_id <= 4'd0;
          end
        default: begin
          state  <= S_IDLE;
          cur_id <= 4'd0;
          int_o  <= '0;
        end
      endcase
    end
  end

  always_comb begin
    rd = '0;
    case (off)
      3'd0: rd = DW'(pend);
      3'd1: rd = DW'(enable);
      3'd2: rd = (state == S_IDLE) ? '0 : DW'(cur_id);
      3'd4: rd = DW'(edge_mode);
      3'd5: rd = DW'({cur_id, 6'b0, state});
      default: rd = '0;
    endcase
  end

  assign mem_rd = sel ? rd : '0;
endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: reset, level/edge pending, claim/complete flow,
// W1C vs. set collision, reset mid-request and the address window.

module tb_int_ctrl;
  localparam logic [15:0] BASE = 16'hFF00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  src_i = '0;
  logic [15:0] mem_addr = '0;
  logic [15:0] mem_wd = '0;
  logic        mem_ctrl = 1'b0;
  logic [15:0] mem_rd;
  logic        sel;
  logic [7:0]  int_o;

  int n_chk = 0;
  int n_fail = 0;

  int_ctrl #(.DW(16), .AW(16), .NSRC(8), .BASE(BASE)) dut (
    .clk      (clk),
    .rst      (rst),
    .src_i    (src_i),
    .mem_addr (mem_addr),
    .mem_wd   (mem_wd),
    .mem_ctrl (mem_ctrl),
    .mem_rd   (mem_rd),
    .sel      (sel),
    .int_o    (int_o)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] off, input logic [15:0] d);
    mem_addr = BASE | 16'(off);
    mem_wd   = d;
    mem_ctrl = 1'b1;
    @(posedge clk);
    #1;
    mem_ctrl = 1'b0;
    mem_addr = '0;
  endtask

  task automatic rd(input logic [2:0] off, output logic [15:0] v);
    mem_addr = BASE | 16'(off);
    #1;
    v = mem_rd;
    mem_addr = '0;
  endtask

  task automatic test_reset;
    logic [15:0] v;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    n_chk++; if (int_o !== 8'h00) begin n_fail++; $display("FAIL reset_int_o got %h exp 00", int_o); end
    rd(3'd0, v);
    n_chk++; if (v !== 16'h0000) begin n_fail++; $display("FAIL reset_pend got %h exp 0000", v); end
    rd(3'd1, v);
    n_chk++; if (v !== 16'h0000) begin n_fail++; $display("FAIL reset_enable got %h exp 0000", v); end
    rd(3'd5, v);
    n_chk++; if (v !== 16'h0000) begin n_fail++; $display("FAIL reset_status got %h exp 0000", v); end
  endtask

  task automatic test_level_masked;
    logic [15:0] v;
    src_i = 8'hFF;
    tick(3);
    rd(3'd0, v);
    n_chk++; if (v !== 16'h00FF) begin n_fail++; $display("FAIL level_pend got %h exp 00ff", v); end
    n_chk++; if (int_o !== 8'h00) begin n_fail++; $display("FAIL level_masked_int_o got %h exp 00", int_o); end
    src_i = 8'h00;
    tick(3);
    rd(3'd0, v);
    n_chk++; if (v !== 16'h0000) begin n_fail++; $display("FAIL level_pend_drop got %h exp 0000", v); end
  endtask

  task automatic test_claim_complete;
    logic [15:0] v;
    wr(3'd4, 16'h00FF);
    wr(3'd1, 16'h000C);
    src_i = 8'h04;
    tick();
    src_i = 8'h08;
    tick();
    src_i = 8'h00;
    tick();
    n_chk++; if (int_o !== 8'h00) begin n_fail++; $display("FAIL edge_latency_early got %h exp 00", int_o); end
    tick();
    n_chk++; if (int_o !== 8'h04) begin n_fail++; $display("FAIL edge_int_o got %h exp 04", int_o); end
    rd(3'd2, v);
    n_chk++; if (v !== 16'h0003) begin n_fail++; $display("FAIL claim_read got %h exp 0003", v); end
    rd(3'd0, v);
    n_chk++; if (v !== 16'h000C) begin n_fail++; $display("FAIL edge_pend got %h exp 000c", v); end
    rd(3'd5, v);
    n_chk++; if (v !== 16'h0301) begin n_fail++; $display("FAIL status_assert got %h exp 0301", v); end
    wr(3'd2, 16'h0000);
    n_chk++; if (int_o !== 8'h00) begin n_fail++; $display("FAIL claim_drop got %h exp 00", int_o); end
    wr(3'd3, 16'h0005);
    rd(3'd5, v);
    n_chk++; if (v !== 16'h0302) begin n_fail++; $display("FAIL bad_complete_status got %h exp 0302", v); end
    rd(3'd2, v);
    n_chk++; if (v !== 16'h0003) begin n_fail++; $display("FAIL claim_wait got %h exp 0003", v); end
    wr(3'd3, 16'h0003);
    rd(3'd5, v);
    n_chk++; if (v !== 16'h0000) begin n_fail++; $display("FAIL complete_status got %h exp 0000", v); end
    n_chk++; if (int_o !== 8'h00) begin n_fail++; $display("FAIL idle_gap got %h exp 00", int_o); end
    tick();
    n_chk++; if (int_o !== 8'h08) begin n_fail++; $display("FAIL next_int_o got %h exp 08", int_o); end
    rd(3'd2, v);
    n_chk++; if (v !== 16'h0004) begin n_fail++; $display("FAIL next_claim got %h exp 0004", v); end
    rd(3'd0, v);
    n_chk++; if (v !== 16'h0008) begin n_fail++; $display("FAIL pend_after_complete got %h exp 0008", v); end
    wr(3'd2, 16'h0000);
    wr(3'd3, 16'h0004);
    rd(3'd0, v);
    n_chk++; if (v !== 16'h0000) begin n_fail++; $display("FAIL pend_cleared got %h exp 0000", v); end
  endtask

  task automatic test_level_withdraw;
    logic [15:0] v;
    wr(3'd4, 16'h00FE);
    wr(3'd1, 16'h0001);
    src_i = 8'h01;
    tick(2);
    n_chk++; if (int_o !== 8'h00) begin n_fail++; $display("FAIL level_latency_early got %h exp 00", int_o); end
    tick();
    n_chk++; if (int_o !== 8'h01) begin n_fail++; $display("FAIL level_int_o got %h exp 01", int_o); end
    src_i = 8'h00;
    tick(2);
    n_chk++; if (int_o !== 8'h01) begin n_fail++; $display("FAIL withdraw_hold got %h exp 01", int_o); end
    tick();
    n_chk++; if (int_o !== 8'h00) begin n_fail++; $display("FAIL withdraw_drop got %h exp 00", int_o); end
    rd(3'd5, v);
    n_chk++; if (v !== 16'h0000) begin n_fail++; $display("FAIL withdraw_status got %h exp 0000", v); end
  endtask

  task automatic test_w1c_collision;
    logic [15:0] v;
    wr(3'd1, 16'h0000);
    wr(3'd4, 16'h00FF);
    src_i = 8'h05;
    tick();
    src_i = 8'h00;
    tick(4);
    rd(3'd0, v);
    n_chk++; if (v !== 16'h0005) begin n_fail++; $display("FAIL w1c_setup got %h exp 0005", v); end
    src_i = 8'h01;
    tick();
    src_i = 8'h00;
    tick();
    wr(3'd0, 16'h0001);
    rd(3'd0, v);
    n_chk++; if (v !== 16'h0005) begin n_fail++; $display("FAIL set_beats_clear got %h exp 0005", v); end
    tick(2);
    wr(3'd0, 16'h0004);
    rd(3'd0, v);
    n_chk++; if (v !== 16'h0001) begin n_fail++; $display("FAIL w1c got %h exp 0001", v); end
  endtask

  task automatic test_reset_assert;
    logic [15:0] v;
    wr(3'd1, 16'h0001);
    tick();
    n_chk++; if (int_o !== 8'h01) begin n_fail++; $display("FAIL pre_reset_int_o got %h exp 01", int_o); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++; if (int_o !== 8'h00) begin n_fail++; $display("FAIL reset_drop_int_o got %h exp 00", int_o); end
    rd(3'd1, v);
    n_chk++; if (v !== 16'h0000) begin n_fail++; $display("FAIL reset_drop_enable got %h exp 0000", v); end
    rd(3'd5, v);
    n_chk++; if (v !== 16'h0000) begin n_fail++; $display("FAIL reset_drop_status got %h exp 0000", v); end
  endtask

  task automatic test_window;
    logic [15:0] v;
    mem_addr = BASE + 16'd9;
    #1;
    n_chk++; if (sel !== 1'b0) begin n_fail++; $display("FAIL out_sel got %b exp 0", sel); end
    n_chk++; if (mem_rd !== 16'h0000) begin n_fail++; $display("FAIL out_rd got %h exp 0000", mem_rd); end
    mem_wd   = 16'h00FF;
    mem_ctrl = 1'b1;
    tick();
    mem_ctrl = 1'b0;
    mem_addr = BASE + 16'd1;
    #1;
    n_chk++; if (sel !== 1'b1) begin n_fail++; $display("FAIL in_sel got %b exp 1", sel); end
    rd(3'd1, v);
    n_chk++; if (v !== 16'h0000) begin n_fail++; $display("FAIL out_write_ignored got %h exp 0000", v); end
  endtask

  initial begin
    test_reset();
    test_level_masked();
    test_claim_complete();
    test_level_withdraw();
    test_w1c_collision();
    test_reset_assert();
    test_window();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
